demux_1x4_32b_buf: RTL and testbench

Registered 32-bit 1-to-4 demultiplexer with valid/ready handshaking, the distribution-side counterpart of the 32-bit 4-to-1 selection path. A single input stream is steered by a 2-bit select (s1, s0) into one of four output channels. Each channel has a one-entry holding register and an 8-bit accepted-word counter. It sits between a producing datapath stage and four consuming units.

---
 rtl/demux_1x4_32b_buf.sv | 146 ++++++++++++++
 tb/tb_demux_1x4_32b_buf.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1x4_32b_buf.sv
// ---------------------------------------------------------------------------
// demux_1x4_32b_buf
//
// Registered 32-bit 1-to-4 demultiplexer with valid/ready handshaking.
// One input stream is steered by {s1,s0} into one of four output channels.
// Each channel owns a one-entry holding register (Yk/vk) and an 8-bit
// wrapping count of the words it has accepted (cntk).
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   s1, s0         channel select, {s1,s0} = 0..3 picks Y0..Y3
//   A              input data word
//   in_valid       A and select are valid this cycle
//   in_ready       block accepts A this cycle (combinational from s1/s0/vk/rk)
//   Y0..Y3         registered channel data
//   v0..v3         channel holds a valid word
//   r0..r3         consumer takes the channel word this cycle
//   cnt0..cnt3     words accepted per channel, modulo 256
// ---------------------------------------------------------------------------
module demux_1x4_32b_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s1,
    input  logic        s0,
    input  logic [31:0] A,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] Y0,
    output logic [31:0] Y1,
    output logic [31:0] Y2,
    output logic [31:0] Y3,
    output logic        v0,
    output logic        v1,
    output logic        v2,
    output logic        v3,
    input  logic        r0,
    input  logic        r1,
    input  logic        r2,
    input  logic        r3,
    output logic [7:0]  cnt0,
    output logic [7:0]  cnt1,
    output logic [7:0]  cnt2,
    output logic [7:0]  cnt3
);

    // Each channel is a one-entry buffer: EMPTY or FULL.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_e;

    chan_state_e state_q [4];
    chan_state_e state_d [4];
    logic [31:0] data_q  [4];
    logic [31:0] data_d  [4];
    logic [7:0]  cnt_q   [4];
    logic [7:0]  cnt_d   [4];

    logic [1:0]  sel;
    logic [3:0]  r_vec;
    logic [3:0]  v_vec;
    logic [3:0]  drain;
    logic [3:0]  load;
    logic        acc;

    assign sel   = {s1, s0};
    assign r_vec = {r3, r2, r1, r0};

    // Valid bits are just the FULL flag of each channel.
    always_comb begin
        v_vec = '0;
        for (int k = 0; k < 4; k++) begin
            v_vec[k] = (state_q[k] == FULL);
        end
    end

    // A word leaves a channel whenever it is held and its consumer is ready.
    assign drain = v_vec & r_vec;

    // The selected channel can take a word if it is empty or is being
    // emptied in this same cycle, so a streaming consumer sees no bubble.
    assign in_ready = ~v_vec[sel] | r_vec[sel];
    assign acc      = in_valid & in_ready;

    // One-hot load strobe for the channel receiving the accepted word.
    always_comb begin
        load = '0;
        if (acc) begin
            load[sel] = 1'b1;
        end
    end

    // Per-channel next state: a load always wins (covers the simultaneous
    // drain + load case, keeping the channel FULL with the new word); a
    // drain without a load empties the channel but leaves the data bits
    // untouched so Yk keeps its last value.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            state_d[k] = state_q[k];
            data_d[k]  = data_q[k];
            cnt_d[k]   = cnt_q[k];
            if (load[k]) begin
                state_d[k] = FULL;
                data_d[k]  = A;
                cnt_d[k]   = cnt_q[k] + 8'd1;
            end else if (drain[k]) begin
                state_d[k] = EMPTY;
            end
        end
    end

    // State registers with synchronous reset; reset discards held words
    // and clears counters, overriding any accept presented meanwhile.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= EMPTY;
                data_q[k]  <= 32'h0;
                cnt_q[k]   <= 8'h0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= state_d[k];
                data_q[k]  <= data_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
        end
    end

    assign Y0 = data_q[0];
    assign Y1 = data_q[1];
    assign Y2 = data_q[2];
    assign Y3 = data_q[3];

    assign v0 = v_vec[0];
    assign v1 = v_vec[1];
    assign v2 = v_vec[2];
    assign v3 = v_vec[3];

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];

endmodule

// File: tb/tb_demux_1x4_32b_buf.sv
// ---------------------------------------------------------------------------
// tb_demux_1x4_32b_buf
//
// Self-checking bench for demux_1x4_32b_buf. Each accepted word is pushed
// into a per-channel expected queue; when a channel drains, the oldest
// queued word is popped and compared with the channel output. Queue
// occupancy also gives the expected vk, and a small counter model gives
// the expected cntk.
// ---------------------------------------------------------------------------
module tb_demux_1x4_32b_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s1, s0;
    logic [31:0] A;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Y0, Y1, Y2, Y3;
    logic        v0, v1, v2, v3;
    logic        r0, r1, r2, r3;
    logic [7:0]  cnt0, cnt1, cnt2, cnt3;

    int check_count = 0;
    int error_count = 0;

    logic [31:0] y_vec   [4];
    logic [7:0]  cnt_vec [4];
    logic [3:0]  v_vec;
    logic [3:0]  r_vec;
    logic [1:0]  sel;

    logic [31:0] exp_q [4][$];
    logic [31:0] last_y    [4];
    logic [7:0]  model_cnt [4];
    bit          model_valid = 1'b0;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    demux_1x4_32b_buf dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s1       (s1),
        .s0       (s0),
        .A        (A),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .Y0       (Y0),
        .Y1       (Y1),
        .Y2       (Y2),
        .Y3       (Y3),
        .v0       (v0),
        .v1       (v1),
        .v2       (v2),
        .v3       (v3),
        .r0       (r0),
        .r1       (r1),
        .r2       (r2),
        .r3       (r3),
        .cnt0     (cnt0),
        .cnt1     (cnt1),
        .cnt2     (cnt2),
        .cnt3     (cnt3)
    );

    assign y_vec[0]   = Y0;
    assign y_vec[1]   = Y1;
    assign y_vec[2]   = Y2;
    assign y_vec[3]   = Y3;
    assign cnt_vec[0] = cnt0;
    assign cnt_vec[1] = cnt1;
    assign cnt_vec[2] = cnt2;
    assign cnt_vec[3] = cnt3;
    assign v_vec      = {v3, v2, v1, v0};
    assign r_vec      = {r3, r2, r1, r0};
    assign sel        = {s1, s0};

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then return just after the capturing edge.
    task automatic applyStimulus(input logic valid, input logic [1:0] s,
                                 input logic [31:0] data, input logic [3:0] rv);
        in_valid = valid;
        {s1, s0} = s;
        A        = data;
        {r3, r2, r1, r0} = rv;
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle monitor: compare DUT state with the model, then advance the
    // model using the inputs the next rising edge will sample.
    always @(negedge clk) begin : monitor
        logic        exp_ready;
        logic        drain_k;
        logic        accept_k;
        logic [31:0] popped;
        exp_ready = 1'b0;
        if (model_valid) begin
            exp_ready = (exp_q[sel].size() == 0) | r_vec[sel];
            checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
            for (int k = 0; k < 4; k++) begin
                checkOutput($sformatf("v%0d", k), 32'(v_vec[k]),
                            32'(exp_q[k].size() != 0));
                checkOutput($sformatf("Y%0d", k), y_vec[k], last_y[k]);
                checkOutput($sformatf("cnt%0d", k), 32'(cnt_vec[k]),
                            32'(model_cnt[k]));
            end
        end
        if (rst_n === 1'b0) begin
            for (int k = 0; k < 4; k++) begin
                exp_q[k].delete();
                last_y[k]    = 32'h0;
                model_cnt[k] = 8'h0;
            end
            model_valid = 1'b1;
        end else if (model_valid) begin
            for (int k = 0; k < 4; k++) begin
                drain_k  = (exp_q[k].size() != 0) && r_vec[k];
                accept_k = in_valid && exp_ready && (sel == 2'(k));
                if (drain_k) begin
                    popped = exp_q[k].pop_front();
                    checkOutput($sformatf("drain%0d", k), y_vec[k], popped);
                end
                if (accept_k) begin
                    exp_q[k].push_back(A);
                    last_y[k]    = A;
                    model_cnt[k] = model_cnt[k] + 8'd1;
                end
            end
        end
    end

    // Directed scenarios followed by random traffic and a counter wrap.
    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        {s1, s0} = 2'd0;
        A        = 32'hDEADBEEF;
        {r3, r2, r1, r0} = 4'b0000;

        // Reset held two cycles with a valid word presented.
        applyStimulus(1'b1, 2'd0, 32'hDEADBEEF, 4'b0000);
        applyStimulus(1'b1, 2'd0, 32'hDEADBEEF, 4'b0000);
        checkOutput("rst_v", 32'(v_vec), 32'h0);
        checkOutput("rst_y0", Y0, 32'h0);
        checkOutput("rst_cnt0", 32'(cnt0), 32'h0);
        rst_n = 1'b1;

        // Basic steering to each channel.
        applyStimulus(1'b1, 2'd0, 32'h11111111, 4'b0000);
        applyStimulus(1'b1, 2'd1, 32'h22222222, 4'b0000);
        applyStimulus(1'b1, 2'd2, 32'h33333333, 4'b0000);
        applyStimulus(1'b1, 2'd3, 32'h44444444, 4'b0000);
        checkOutput("steer_y0", Y0, 32'h11111111);
        checkOutput("steer_y1", Y1, 32'h22222222);
        checkOutput("steer_y2", Y2, 32'h33333333);
        checkOutput("steer_y3", Y3, 32'h44444444);
        checkOutput("steer_v", 32'(v_vec), 32'hF);
        checkOutput("steer_cnt3", 32'(cnt3), 32'h1);

        // Backpressure on channel 2, then release.
        in_valid = 1'b1;
        {s1, s0} = 2'd2;
        A        = 32'hCAFE0000;
        {r3, r2, r1, r0} = 4'b0000;
        #1;
        checkOutput("bp_ready_lo", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("bp_hold_y2", Y2, 32'h33333333);
        {r3, r2, r1, r0} = 4'b0100;
        #1;
        checkOutput("bp_ready_hi", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        checkOutput("bp_y2", Y2, 32'hCAFE0000);
        checkOutput("bp_v2", 32'(v2), 32'h1);

        // Streaming into channel 1 with its consumer always ready.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 2'd1, 32'hA0000000 + 32'(i), 4'b0010);
        end
        checkOutput("stream_y1", Y1, 32'hA0000007);
        checkOutput("stream_v1", 32'(v1), 32'h1);
        checkOutput("stream_cnt1", 32'(cnt1), 32'd9);

        // Cross-channel: empty channel 2 first, then drain 0 while loading 2.
        applyStimulus(1'b0, 2'd2, 32'h0, 4'b0100);
        applyStimulus(1'b1, 2'd2, 32'hBEEF0002, 4'b0001);
        checkOutput("cross_v0", 32'(v0), 32'h0);
        checkOutput("cross_v2", 32'(v2), 32'h1);
        checkOutput("cross_y2", Y2, 32'hBEEF0002);
        checkOutput("cross_cnt0", 32'(cnt0), 32'h1);
        checkOutput("cross_cnt2", 32'(cnt2), 32'h3);

        // Random traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          $urandom, 4'($urandom_range(0, 15)));
        end

        // Reset mid-operation discards held words.
        rst_n = 1'b0;
        applyStimulus(1'b1, 2'd0, 32'hDEADBEEF, 4'b1111);
        rst_n = 1'b1;
        checkOutput("mid_rst_v", 32'(v_vec), 32'h0);
        checkOutput("mid_rst_cnt1", 32'(cnt1), 32'h0);

        // Counter wrap on channel 3.
        for (int i = 1; i <= 256; i++) begin
            applyStimulus(1'b1, 2'd3, $urandom, 4'b1000);
            if (i == 255) checkOutput("wrap_255", 32'(cnt3), 32'd255);
            if (i == 256) checkOutput("wrap_0", 32'(cnt3), 32'd0);
        end
        checkOutput("wrap_cnt0", 32'(cnt0), 32'h0);

        applyStimulus(1'b0, 2'd0, 32'h0, 4'b0000);
        applyStimulus(1'b0, 2'd0, 32'h0, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
